fetch_unit: RTL and testbench

- Instruction-side datapath block answering the CPU controller's PC/IR commands (PCWrite, PCIncrement, PCImmediate, PCReset, IRWrite, IRReset).
- Owns the program counter and instruction register.
- Fetches from instruction memory over a request/ready handshake with variable wait states.
- Returns INS to the controller, and raises Stall while a fetch is outstanding so the controller holds its state.

---
 rtl/fetch_unit_pkg.sv | 7 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_pc.sv | 27 ++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset defaults and fetch FSM encoding
package fetch_unit_pkg;
   localparam int XLEN = 16;
   localparam logic [XLEN-1:0] NOP_INS_DEF = 16'hF000;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 16'h0000;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read handshake
interface fetch_unit_if;
   import fetch_unit_pkg::*;
   logic            MemReady;
   logic [XLEN-1:0] MemData;
   logic [XLEN-1:0] MemAddr;
   logic            MemReadReq;
   modport master (output MemAddr, MemReadReq, input MemReady, MemData);
   modport slave (input MemAddr, MemReadReq, output MemReady, MemData);
endinterface

// File: rtl/fetch_unit_pc.sv
// pc_register: program counter with prioritised reset/hold/jump/relative update
module pc_register
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            pc_reset_n_i,
   input  logic            stall_i,
   input  logic            pc_write_i,
   input  logic            pc_inc_i,
   input  logic [7:0]      imm_i,
   input  logic [XLEN-1:0] target_i,
   output logic [XLEN-1:0] pc_o
);
   logic [XLEN-1:0] pc_q, pc_d;
   always_comb
      pc_d = !pc_reset_n_i ? RESET_VECTOR :
             stall_i       ? pc_q :
             pc_write_i    ? target_i :
             pc_inc_i      ? pc_q + {{(XLEN-8){imm_i[7]}}, imm_i} : pc_q;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) pc_q <= RESET_VECTOR;
      else pc_q <= pc_d;
   assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns PC and IR, fetches instructions over a ready handshake with timeout
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int              MAX_WAIT     = 15,
   parameter logic [XLEN-1:0] NOP_INS      = NOP_INS_DEF
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            PCWrite,
   input  logic            PCIncrement,
   input  logic [7:0]      PCImmediate,
   input  logic [XLEN-1:0] PCTarget,
   input  logic            PCReset,
   input  logic            IRWrite,
   input  logic            IRReset,
   fetch_unit_if.master    mem,
   output logic [XLEN-1:0] INS,
   output logic [XLEN-1:0] PC,
   output logic            Stall,
   output logic            Fault
);
   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
   fetch_state_e    state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] ins_q, ins_d, addr_q, addr_d;
   logic            req_q, req_d, stall_q, stall_d, fault_q, fault_d;
   logic            in_wait, timeout, start;
   assign in_wait = state_q == WAIT;
   assign timeout = in_wait && !mem.MemReady && cnt_q == LAST;
   assign start   = state_q == IDLE && IRWrite && IRReset;
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ins_q   <= NOP_INS;
         addr_q  <= '0;
         req_q   <= 1'b0;
         stall_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ins_q   <= ins_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         stall_q <= stall_d;
         fault_q <= fault_d;
      end
   // IRReset aborts any fetch and wins over a same-edge MemReady
   always_comb
      state_d = !IRReset ? IDLE :
                state_q == IDLE ? (IRWrite ? WAIT : IDLE) :
                in_wait ? ((mem.MemReady || timeout) ? DONE : WAIT) : IDLE;
   always_comb begin
      cnt_d   = start ? '0 : in_wait ? cnt_q + 8'd1 : cnt_q;
      addr_d  = start ? PC : addr_q;
      req_d   = state_d == WAIT;
      stall_d = state_d != IDLE;
      ins_d   = !IRReset ? NOP_INS :
                in_wait && mem.MemReady ? mem.MemData :
                timeout ? NOP_INS : ins_q;
      fault_d = fault_q | (IRReset && timeout);
   end
   pc_register #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
      .clk_i       (Clock),
      .rst_n_i     (Reset),
      .pc_reset_n_i(PCReset),
      .stall_i     (stall_q),
      .pc_write_i  (PCWrite),
      .pc_inc_i    (PCIncrement),
      .imm_i       (PCImmediate),
      .target_i    (PCTarget),
      .pc_o        (PC)
   );
   assign mem.MemAddr    = addr_q;
   assign mem.MemReadReq = req_q;
   assign INS            = ins_q;
   assign Stall          = stall_q;
   assign Fault          = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a fetch scoreboard checked by a monitor
module tb_fetch_unit;
   typedef struct {
      logic [15:0] addr;
      logic [15:0] ins;
      logic        fault;
      int          cycles;
   } exp_t;
   exp_t q[$];
   logic clk = 0, Reset = 0;
   logic PCWrite = 0, PCIncrement = 0, PCReset = 1, IRWrite = 0, IRReset = 1;
   logic [7:0] PCImmediate = 0;
   logic [15:0] PCTarget = 0, INS, PC;
   logic Stall, Fault;
   int n_checks = 0, n_pass = 0;
   int stall_cnt = 0;
   logic prev_stall = 0;
   fetch_unit_if mem();
   fetch_unit #(.RESET_VECTOR(16'h0000), .MAX_WAIT(15), .NOP_INS(16'hF000)) dut (
      .Clock(clk), .Reset(Reset), .PCWrite(PCWrite), .PCIncrement(PCIncrement),
      .PCImmediate(PCImmediate), .PCTarget(PCTarget), .PCReset(PCReset),
      .IRWrite(IRWrite), .IRReset(IRReset), .mem(mem.master),
      .INS(INS), .PC(PC), .Stall(Stall), .Fault(Fault)
   );
   always #5 clk = ~clk;
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_pc(logic [15:0] v);
      PCWrite = 1; PCTarget = v;
      step();
      PCWrite = 0;
   endtask
   task automatic incr(logic [7:0] imm);
      PCIncrement = 1; PCImmediate = imm;
      step();
      PCIncrement = 0;
   endtask
   task automatic push(logic [15:0] a, logic [15:0] i, logic f, int c);
      exp_t e;
      e.addr = a; e.ins = i; e.fault = f; e.cycles = c;
      q.push_back(e);
   endtask
   always @(negedge clk) begin
      if (!Reset) begin
         prev_stall = 0;
         stall_cnt = 0;
      end else begin
         if (Stall) begin
            stall_cnt++;
            if (mem.MemReadReq && q.size() != 0) check("memaddr", mem.MemAddr, q[0].addr);
         end
         if (prev_stall && !Stall) begin
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_fetch_end: got fetch completion expected none");
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sb_ins", INS, e.ins);
               check("sb_fault", Fault, e.fault);
               check("sb_stall_cycles", stall_cnt, e.cycles);
            end
            stall_cnt = 0;
         end
         prev_stall = Stall;
      end
   end
   initial begin
      mem.MemReady = 0; mem.MemData = 0;
      #22;
      check("rst_pc", PC, 16'h0000);
      check("rst_ins", INS, 16'hF000);
      check("rst_req", mem.MemReadReq, 0);
      check("rst_stall", Stall, 0);
      check("rst_fault", Fault, 0);
      Reset = 1;
      PCIncrement = 1; PCImmediate = 8'h01;
      check("inc0", PC, 16'h0000);
      step(); check("inc1", PC, 16'h0001);
      step(); check("inc2", PC, 16'h0002);
      step(); check("inc3", PC, 16'h0003);
      PCIncrement = 0;
      check("inc_ins", INS, 16'hF000);
      check("inc_stall", Stall, 0);
      // fetch with MemReady in the third WAIT cycle
      set_pc(16'h0010);
      push(16'h0010, 16'h0123, 0, 4);
      IRWrite = 1; step(); IRWrite = 0;
      step(); step();
      mem.MemReady = 1; mem.MemData = 16'h0123;
      step();
      mem.MemReady = 0;
      check("fetch_ins", INS, 16'h0123);
      check("fetch_req", mem.MemReadReq, 0);
      step();
      check("fetch_stall_low", Stall, 0);
      check("fetch_pc", PC, 16'h0010);
      // branch arithmetic
      set_pc(16'h0005); incr(8'hFB); check("br_neg", PC, 16'h0000);
      set_pc(16'hFFFF); incr(8'h01); check("br_wrap", PC, 16'h0000);
      PCIncrement = 1; PCImmediate = 8'h01;
      set_pc(16'h1234); PCIncrement = 0;
      check("br_write_prio", PC, 16'h1234);
      set_pc(16'h0000); incr(8'hFF); check("br_under", PC, 16'hFFFF);
      // timeout; PCIncrement and IRWrite during stall are ignored
      push(16'hFFFF, 16'hF000, 1, 16);
      IRWrite = 1; step();
      PCIncrement = 1; PCImmediate = 8'h01;
      step();
      IRWrite = 0; PCIncrement = 0;
      check("stall_pc_hold", PC, 16'hFFFF);
      repeat (13) step();
      check("to_req_held", mem.MemReadReq, 1);
      step();
      check("to_req_drop", mem.MemReadReq, 0);
      check("to_fault", Fault, 1);
      check("to_ins", INS, 16'hF000);
      step();
      // good fetch at minimum latency with PCReset during stall
      push(16'hFFFF, 16'h5A5A, 1, 2);
      IRWrite = 1; step(); IRWrite = 0;
      PCReset = 0; mem.MemReady = 1; mem.MemData = 16'h5A5A;
      step();
      PCReset = 1; mem.MemReady = 0;
      check("stall_pcreset", PC, 16'h0000);
      step();
      check("fault_sticky", Fault, 1);
      // IRReset abort wins over same-edge MemReady
      push(16'h0000, 16'hF000, 1, 1);
      IRWrite = 1; step(); IRWrite = 0;
      IRReset = 0; mem.MemReady = 1; mem.MemData = 16'hABCD;
      step();
      IRReset = 1;
      check("abort_ins", INS, 16'hF000);
      check("abort_stall", Stall, 0);
      check("abort_req", mem.MemReadReq, 0);
      step();
      check("ready_idle_ignored", INS, 16'hF000);
      mem.MemReady = 0;
      set_pc(16'h0042);
      for (int i = 0; i < 50 && q.size() != 0; i++) step();
      check("sb_drain", q.size(), 0);
      // asynchronous reset in the middle of a fetch
      IRWrite = 1; step(); IRWrite = 0;
      step();
      check("pre_areset_req", mem.MemReadReq, 1);
      #1 Reset = 0;
      #1;
      check("areset_pc", PC, 16'h0000);
      check("areset_ins", INS, 16'hF000);
      check("areset_addr", mem.MemAddr, 16'h0000);
      check("areset_req", mem.MemReadReq, 0);
      check("areset_stall", Stall, 0);
      check("areset_fault", Fault, 0);
      step();
      Reset = 1;
      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
